// File: rtl/qsfp_link_pkg.sv
// qsfp_link_pkg: shared beat type, link FSM states and width helpers for the QSFP link model.
package qsfp_link_pkg;
    localparam int QSFP_DATA_BITS = 256;
    typedef struct packed {
        logic                      valid;
        logic [QSFP_DATA_BITS-1:0] bits;
    } qsfp_beat_t;
    typedef enum logic {TRAIN, UP} link_state_e;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/qsfp_link_fifo.sv
// qsfp_link_fifo: DEPTH-entry receive FIFO with a registered head; an empty FIFO loads a write straight into the head.
module qsfp_link_fifo
    import qsfp_link_pkg::*;
#(
    parameter int DATA_BITS = QSFP_DATA_BITS,
    parameter int DEPTH     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_bits,
    input  logic                 rx_ready
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic                 head_v_q, head_v_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic                 empty, full, head_free, mem_rd, bypass, mem_wr;
    assign empty     = wp_q == rp_q;
    assign full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign head_free = !head_v_q || rx_ready;
    assign mem_rd    = head_free && !empty;
    assign bypass    = head_free && empty && wr_en;
    assign mem_wr    = wr_en && !bypass;
    assign rx_valid  = head_v_q;
    assign rx_bits   = head_q;
    always_comb begin
        wp_d     = mem_wr ? wp_q + PW'(1) : wp_q;
        rp_d     = mem_rd ? rp_q + PW'(1) : rp_q;
        head_v_d = head_free ? (mem_rd || wr_en) : head_v_q;
        head_d   = mem_rd ? mem_q[rp_q[AW-1:0]] : bypass ? wr_data : head_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            head_v_q <= 1'b0;
            head_q   <= '0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            head_v_q <= head_v_d;
            head_q   <= head_d;
        end
    end
    always_ff @(posedge clock)
        if (mem_wr) mem_q[wp_q[AW-1:0]] <= wr_data;
`ifndef SYNTHESIS
    always_ff @(posedge clock)
        if (reset) assert (!(mem_wr && full)) else $error("qsfp_link_fifo: write into full FIFO");
`endif
endmodule

// File: rtl/qsfp_link_model.sv
// qsfp_link_model: QSFP cable model - credit-gated tx, fixed wire latency, rx FIFO and trained channel_up.
// Define QSFP_LINK_STATS_EN to add beat counters and peak-occupancy stats ports.
module qsfp_link_model
    import qsfp_link_pkg::*;
#(
    parameter int DATA_BITS = QSFP_DATA_BITS,
    parameter int LATENCY   = 8,
    parameter int DEPTH     = 16,
    parameter int UP_DELAY  = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        tx_valid,
    input  logic [DATA_BITS-1:0]        tx_bits,
    output logic                        tx_ready,
    output logic                        rx_valid,
    output logic [DATA_BITS-1:0]        rx_bits,
    input  logic                        rx_ready,
    output logic                        channel_up
`ifdef QSFP_LINK_STATS_EN
    ,
    output logic [31:0]                 stat_tx_beats,
    output logic [31:0]                 stat_rx_beats,
    output logic [$clog2(DEPTH+1)-1:0]  stat_max_occ
`endif
);
    localparam int CW = cred_w(DEPTH);
    typedef struct packed {
        logic                 valid;
        logic [DATA_BITS-1:0] bits;
    } beat_t;
    link_state_e   state_q, state_d;
    logic [15:0]   up_cnt_q, up_cnt_d;
    logic          channel_up_q, channel_up_d;
    logic [CW-1:0] credits_q, credits_d;
    beat_t         dl_q [LATENCY];
    beat_t         dl_d [LATENCY];
    logic          accept, pop;
    assign tx_ready   = channel_up_q && (credits_q != '0);
    assign channel_up = channel_up_q;
    assign accept     = tx_valid && tx_ready;
    assign pop        = rx_valid && rx_ready;
    always_comb begin
        up_cnt_d     = (state_q == TRAIN) ? up_cnt_q + 16'd1 : up_cnt_q;
        state_d      = (state_q == TRAIN && up_cnt_q == 16'(UP_DELAY - 1)) ? UP : state_q;
        channel_up_d = state_d == UP;
        credits_d    = credits_q - CW'(accept) + CW'(pop);
        dl_d[0]      = '{valid: accept, bits: tx_bits};
        for (int i = 1; i < LATENCY; i++) dl_d[i] = dl_q[i-1];
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= TRAIN;
            up_cnt_q     <= '0;
            channel_up_q <= 1'b0;
            credits_q    <= CW'(DEPTH);
            dl_q         <= '{default: '0};
        end else begin
            state_q      <= state_d;
            up_cnt_q     <= up_cnt_d;
            channel_up_q <= channel_up_d;
            credits_q    <= credits_d;
            dl_q         <= dl_d;
        end
    end
    qsfp_link_fifo #(.DATA_BITS(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (dl_q[LATENCY-1].valid),
        .wr_data  (dl_q[LATENCY-1].bits),
        .rx_valid (rx_valid),
        .rx_bits  (rx_bits),
        .rx_ready (rx_ready)
    );
`ifdef QSFP_LINK_STATS_EN
    logic [31:0]   stat_tx_q, stat_tx_d, stat_rx_q, stat_rx_d;
    logic [CW-1:0] max_occ_q, max_occ_d, occ;
    assign occ = CW'(DEPTH) - credits_q;
    always_comb begin
        stat_tx_d = stat_tx_q + 32'(accept);
        stat_rx_d = stat_rx_q + 32'(pop);
        max_occ_d = (occ > max_occ_q) ? occ : max_occ_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_tx_q <= '0;
            stat_rx_q <= '0;
            max_occ_q <= '0;
        end else begin
            stat_tx_q <= stat_tx_d;
            stat_rx_q <= stat_rx_d;
            max_occ_q <= max_occ_d;
        end
    end
    assign stat_tx_beats = stat_tx_q;
    assign stat_rx_beats = stat_rx_q;
    assign stat_max_occ  = max_occ_q;
`endif
`ifndef SYNTHESIS
    always_ff @(posedge clock)
        if (reset) assert (credits_q <= CW'(DEPTH)) else $error("qsfp_link_model: credit counter out of range");
`endif
endmodule

// File: tb/tb_qsfp_link_model.sv
// tb_qsfp_link_model: directed self-checking bench for qsfp_link_model (LATENCY=8, DEPTH=16, UP_DELAY=32).
module tb_qsfp_link_model;
    localparam int DW  = 256;
    localparam int LAT = 8;
    localparam int DEP = 16;
    localparam int UPD = 32;
    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tx_valid = 1'b0;
    logic [DW-1:0] tx_bits = '0;
    logic          tx_ready;
    logic          rx_valid;
    logic [DW-1:0] rx_bits;
    logic          rx_ready = 1'b0;
    logic          channel_up;
    int            vectors = 0;
    int            miscompares = 0;
    always #5 clock = ~clock;
`ifdef QSFP_LINK_STATS_EN
    logic [31:0]   m_stat_tx, m_stat_rx;
    logic [4:0]    m_stat_occ;
    logic          s_tx_valid = 1'b0;
    logic [DW-1:0] s_tx_bits = '0;
    logic          s_tx_ready, s_rx_valid, s_channel_up;
    logic [DW-1:0] s_rx_bits;
    logic          s_rx_ready = 1'b0;
    logic [31:0]   s_stat_tx, s_stat_rx;
    logic [5:0]    s_stat_occ;
    qsfp_link_model #(.DATA_BITS(DW), .LATENCY(LAT), .DEPTH(32), .UP_DELAY(UPD)) u_stats_dut (
        .clock(clock), .reset(reset), .tx_valid(s_tx_valid), .tx_bits(s_tx_bits), .tx_ready(s_tx_ready),
        .rx_valid(s_rx_valid), .rx_bits(s_rx_bits), .rx_ready(s_rx_ready), .channel_up(s_channel_up),
        .stat_tx_beats(s_stat_tx), .stat_rx_beats(s_stat_rx), .stat_max_occ(s_stat_occ)
    );
`endif
    qsfp_link_model #(.DATA_BITS(DW), .LATENCY(LAT), .DEPTH(DEP), .UP_DELAY(UPD)) dut (
        .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_bits(tx_bits), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_bits(rx_bits), .rx_ready(rx_ready), .channel_up(channel_up)
`ifdef QSFP_LINK_STATS_EN
        , .stat_tx_beats(m_stat_tx), .stat_rx_beats(m_stat_rx), .stat_max_occ(m_stat_occ)
`endif
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        repeat (UPD) step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tx_valid = 1'b1;
        tx_bits = DW'(1);
        repeat (3) step();
        vectors++;
        if (tx_ready !== 1'b0 || rx_valid !== 1'b0 || channel_up !== 1'b0 || rx_bits !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b rxv=%b up=%b bits=%0h, expected all 0", tx_ready, rx_valid, channel_up, rx_bits);
        end
        reset = 1'b1;
        for (int i = 1; i <= UPD; i++) begin
            step();
            vectors++;
            if (channel_up !== (i == UPD) || tx_ready !== (i == UPD) || rx_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL train_edge%0d: got up=%b rdy=%b rxv=%b, expected up=rdy=%b rxv=0", i, channel_up, tx_ready, rx_valid, i == UPD);
            end
        end
        tx_valid = 1'b0;
        repeat (LAT + 2) step();
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL train_no_rx: got rx_valid=%b, expected 0", rx_valid);
        end
    endtask

    task automatic test_single_beat();
        tx_valid = 1'b1;
        tx_bits = DW'(8'hA5);
        vectors++;
        if (tx_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_ready: got tx_ready=%b, expected 1", tx_ready);
        end
        step();
        tx_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            step();
            vectors++;
            if (rx_valid !== (k == LAT) || (k == LAT && rx_bits !== DW'(8'hA5))) begin
                miscompares++;
                $display("FAIL single_lat%0d: got rxv=%b bits=%0h, expected rxv=%b bits=a5", k, rx_valid, rx_bits, k == LAT);
            end
        end
        step();
        vectors++;
        if (rx_valid !== 1'b1 || rx_bits !== DW'(8'hA5)) begin
            miscompares++;
            $display("FAIL single_hold: got rxv=%b bits=%0h, expected 1/a5", rx_valid, rx_bits);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop: got rx_valid=%b, expected 0", rx_valid);
        end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int more = 0;
        int exp_b = 1;
        rx_ready = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tx_bits = DW'(acc);
            if (tx_ready) acc++;
            step();
        end
        vectors++;
        if (acc !== DEP || tx_ready !== 1'b0 || rx_valid !== 1'b1 || rx_bits !== '0) begin
            miscompares++;
            $display("FAIL bp_fill: got accepts=%0d rdy=%b rxv=%b head=%0h, expected 16/0/1/0", acc, tx_ready, rx_valid, rx_bits);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        vectors++;
        if (tx_ready !== 1'b1 || rx_bits !== DW'(1)) begin
            miscompares++;
            $display("FAIL bp_credit_return: got rdy=%b head=%0h, expected 1/1", tx_ready, rx_bits);
        end
        for (int i = 0; i < 20; i++) begin
            tx_bits = DW'(acc + more);
            if (tx_ready) more++;
            step();
        end
        vectors++;
        if (more !== 1 || tx_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_one_more: got accepts=%0d rdy=%b, expected 1/0", more, tx_ready);
        end
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (rx_valid) begin
                vectors++;
                if (rx_bits !== DW'(exp_b)) begin
                    miscompares++;
                    $display("FAIL bp_drain: got %0h, expected %0h", rx_bits, exp_b);
                end
                exp_b++;
            end
            step();
        end
        rx_ready = 1'b0;
        vectors++;
        if (exp_b !== DEP + 1) begin
            miscompares++;
            $display("FAIL bp_drain_count: got last+1=%0d, expected %0d", exp_b, DEP + 1);
        end
    endtask

    task automatic test_stream();
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            rx_ready = 1'($urandom_range(0, 1));
            tx_valid = (sent < 1000);
            tx_bits = DW'(sent);
            vectors++;
            if (tx_ready !== ((sent - got) < DEP)) begin
                miscompares++;
                $display("FAIL stream_credit: got tx_ready=%b, expected %b (outstanding %0d)", tx_ready, (sent - got) < DEP, sent - got);
            end
            if (rx_valid && rx_ready) begin
                vectors++;
                if (rx_bits !== DW'(got)) begin
                    miscompares++;
                    $display("FAIL stream_order: got %0h, expected %0h", rx_bits, got);
                end
                got++;
            end
            if (tx_valid && tx_ready) sent++;
            step();
            cyc++;
        end
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        vectors++;
        if (got !== 1000 || sent !== 1000) begin
            miscompares++;
            $display("FAIL stream_count: got sent=%0d received=%0d, expected 1000/1000", sent, got);
        end
    endtask

    task automatic test_reset_midflight();
        int acc = 0;
        rx_ready = 1'b0;
        tx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_bits = DW'(100 + i);
            step();
        end
        tx_valid = 1'b0;
        repeat (LAT + 2) step();
        vectors++;
        if (rx_valid !== 1'b1 || rx_bits !== DW'(100)) begin
            miscompares++;
            $display("FAIL mid_buffered: got rxv=%b head=%0h, expected 1/64", rx_valid, rx_bits);
        end
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_bits = DW'(200 + i);
            step();
        end
        tx_valid = 1'b0;
        reset = 1'b0;
        repeat (2) step();
        vectors++;
        if (tx_ready !== 1'b0 || rx_valid !== 1'b0 || channel_up !== 1'b0 || rx_bits !== '0) begin
            miscompares++;
            $display("FAIL mid_in_reset: got rdy=%b rxv=%b up=%b bits=%0h, expected all 0", tx_ready, rx_valid, channel_up, rx_bits);
        end
        reset = 1'b1;
        for (int i = 1; i <= UPD; i++) begin
            step();
            vectors++;
            if (channel_up !== (i == UPD) || tx_ready !== (i == UPD) || rx_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_retrain%0d: got up=%b rdy=%b rxv=%b, expected up=rdy=%b rxv=0", i, channel_up, tx_ready, rx_valid, i == UPD);
            end
        end
        tx_valid = 1'b1;
        tx_bits = DW'(1);
        step();
        tx_valid = 1'b0;
        repeat (LAT) step();
        vectors++;
        if (rx_valid !== 1'b1 || rx_bits !== DW'(1)) begin
            miscompares++;
            $display("FAIL mid_new_beat: got rxv=%b bits=%0h, expected 1/1", rx_valid, rx_bits);
        end
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
        repeat (LAT + 2) step();
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_no_stale: got rx_valid=%b, expected 0", rx_valid);
        end
        tx_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (tx_ready) acc++;
            step();
        end
        tx_valid = 1'b0;
        vectors++;
        if (acc !== DEP) begin
            miscompares++;
            $display("FAIL mid_credits: got accepts=%0d, expected %0d", acc, DEP);
        end
        do_reset();
    endtask

`ifdef QSFP_LINK_STATS_EN
    task automatic test_stats();
        do_reset();
        s_rx_ready = 1'b0;
        s_tx_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tx_bits = DW'(i);
            step();
        end
        s_tx_valid = 1'b0;
        repeat (LAT + 2) step();
        vectors++;
        if (s_stat_tx !== 32'd20 || s_stat_rx !== 32'd0 || s_stat_occ !== 6'd20) begin
            miscompares++;
            $display("FAIL stats_fill: got tx=%0d rx=%0d occ=%0d, expected 20/0/20", s_stat_tx, s_stat_rx, s_stat_occ);
        end
        s_rx_ready = 1'b1;
        repeat (12) step();
        s_rx_ready = 1'b0;
        step();
        vectors++;
        if (s_stat_tx !== 32'd20 || s_stat_rx !== 32'd12 || s_stat_occ !== 6'd20 || s_rx_bits !== DW'(12)) begin
            miscompares++;
            $display("FAIL stats_pop: got tx=%0d rx=%0d occ=%0d head=%0h, expected 20/12/20/c", s_stat_tx, s_stat_rx, s_stat_occ, s_rx_bits);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_backpressure();
        test_stream();
        test_reset_midflight();
`ifdef QSFP_LINK_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
